axi_wr_arbiter: RTL

//  Two-channel write scheduler in front of the AXI4 write master (wr_start/wr_done user interface).

---
 rtl/axi_wr_pkg.sv | 24 ++
 rtl/axi_wr_arbiter_if.sv | 24 ++
 rtl/wr_addr_gen.sv | 32 +++
 rtl/axi_wr_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the two-channel AXI write scheduler.
package axi_wr_pkg;

  localparam int unsigned AXI_BEAT_BYTES = 8;
  localparam int unsigned ADDR_W         = 30;
  localparam int unsigned DATA_W         = 64;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   addr_ext_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StStart = 2'd2,
    StBusy  = 2'd3
  } state_e;

  // One extra bit so that ptr + step cannot overflow before the end-of-region compare.
  function automatic addr_ext_t burst_step(input int unsigned burst_len);
    return addr_ext_t'(burst_len * AXI_BEAT_BYTES);
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// User-side handshake between the write scheduler and the AXI4 write master.
interface axi_wr_arbiter_if;
  import axi_wr_pkg::*;

  logic       wr_ready;
  logic       wr_done;
  logic       w_handshake;
  logic       wr_start;
  addr_t      wr_addr;
  logic [7:0] wr_len;
  data_t      wr_data;
  logic       busy;

  modport master (
    input  wr_ready, wr_done, w_handshake,
    output wr_start, wr_addr, wr_len, wr_data, busy
  );

  modport slave (
    output wr_ready, wr_done, w_handshake,
    input  wr_start, wr_addr, wr_len, wr_data, busy
  );

endinterface

// File: rtl/wr_addr_gen.sv
// Per-channel circular DDR address pointer; clear has priority over advance.
module wr_addr_gen
  import axi_wr_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  addr_t     i_base,
  input  addr_t     i_end,
  input  addr_ext_t i_step,
  input  logic      i_adv,
  input  logic      i_clr,
  output addr_t     o_ptr
);

  addr_t     r_ptr;
  addr_ext_t w_next;

  assign w_next = {1'b0, r_ptr} + i_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= i_base;
    end else if (i_clr) begin
      r_ptr <= i_base;
    end else if (i_adv) begin
      r_ptr <= (w_next >= {1'b0, i_end}) ? i_base : w_next[ADDR_W-1:0];
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin write scheduler: grants the AXI write master to whichever FWFT FIFO holds a burst.
module axi_wr_arbiter
  import axi_wr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned CNT_W     = 10,
  parameter addr_t       CH0_BASE  = 30'h0000000,
  parameter addr_t       CH0_END   = 30'h0100000,
  parameter addr_t       CH1_BASE  = 30'h0100000,
  parameter addr_t       CH1_END   = 30'h0200000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ch0_en,
  input  logic [CNT_W-1:0] i_ch0_fifo_cnt,
  input  data_t            i_ch0_fifo_dout,
  output logic             o_ch0_fifo_rden,
  input  logic             i_ch0_addr_clr,
  input  logic             i_ch1_en,
  input  logic [CNT_W-1:0] i_ch1_fifo_cnt,
  input  data_t            i_ch1_fifo_dout,
  output logic             o_ch1_fifo_rden,
  input  logic             i_ch1_addr_clr,
  axi_wr_arbiter_if.master wr_if
);

  localparam addr_ext_t  STEP    = burst_step(BURST_LEN);
  localparam logic [7:0] LEN_M1  = 8'(BURST_LEN - 1);

  state_e     r_state;
  logic       r_grant;
  logic       r_last_grant;
  logic       r_wr_start;
  logic       r_busy;
  addr_t      r_wr_addr;
  logic [1:0] r_clr_pend;

  logic [1:0] w_req;
  logic       w_arb_ok;
  logic       w_arb_gnt;
  logic [1:0] w_inflight;
  logic [1:0] w_adv;
  logic [1:0] w_clr_in;
  logic [1:0] w_clr;
  addr_t      w_ptr0;
  addr_t      w_ptr1;

  assign w_req[0]  = i_ch0_en & (32'(i_ch0_fifo_cnt) >= BURST_LEN);
  assign w_req[1]  = i_ch1_en & (32'(i_ch1_fifo_cnt) >= BURST_LEN);
  assign w_arb_ok  = |w_req;
  assign w_arb_gnt = (&w_req) ? ~r_last_grant : w_req[1];
  assign w_clr_in  = {i_ch1_addr_clr, i_ch0_addr_clr};

  // A channel is in flight from the arbitration cycle that picks it until its wr_done.
  always_comb begin
    w_inflight = '0;
    w_adv      = '0;
    if (r_state == StArb && w_arb_ok) begin
      w_inflight[w_arb_gnt] = 1'b1;
    end
    if (r_state == StStart || r_state == StBusy) begin
      w_inflight[r_grant] = 1'b1;
    end
    if (r_state == StBusy && wr_if.wr_done) begin
      w_adv[r_grant] = 1'b1;
    end
  end

  // Clears during a channel's own burst wait for wr_done and replace the increment.
  assign w_clr = (w_clr_in & ~w_inflight) | (w_adv & (r_clr_pend | w_clr_in));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clr_pend <= '0;
    end else begin
      r_clr_pend <= (r_clr_pend | (w_clr_in & w_inflight)) & ~w_adv;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wr_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (wr_if.wr_ready && w_arb_ok) begin
            r_state <= StArb;
          end
        end
        StArb: begin
          if (w_arb_ok) begin
            r_grant   <= w_arb_gnt;
            r_wr_addr <= w_arb_gnt ? w_ptr1 : w_ptr0;
            r_state   <= StStart;
          end else begin
            r_state <= StIdle;
          end
        end
        StStart: begin
          r_wr_start <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= StBusy;
        end
        StBusy: begin
          r_wr_start <= 1'b0;
          if (wr_if.wr_done) begin
            r_last_grant <= r_grant;
            r_busy       <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  wr_addr_gen u_ch0_addr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_base (CH0_BASE),
    .i_end  (CH0_END),
    .i_step (STEP),
    .i_adv  (w_adv[0]),
    .i_clr  (w_clr[0]),
    .o_ptr  (w_ptr0)
  );

  wr_addr_gen u_ch1_addr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_base (CH1_BASE),
    .i_end  (CH1_END),
    .i_step (STEP),
    .i_adv  (w_adv[1]),
    .i_clr  (w_clr[1]),
    .o_ptr  (w_ptr1)
  );

  assign o_ch0_fifo_rden = wr_if.w_handshake & (r_state == StBusy) & ~r_grant;
  assign o_ch1_fifo_rden = wr_if.w_handshake & (r_state == StBusy) & r_grant;

  assign wr_if.wr_start = r_wr_start;
  assign wr_if.wr_addr  = r_wr_addr;
  assign wr_if.wr_len   = LEN_M1;
  assign wr_if.wr_data  = r_grant ? i_ch1_fifo_dout : i_ch0_fifo_dout;
  assign wr_if.busy     = r_busy;

endmodule
